// File: rtl/bp_be_pkg.sv
// Shared types for the late writeback queue: entry format, producer indices and arbiter states.
package bp_be_pkg;

  typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int dword_width_gp    = 64;
  localparam int reg_addr_width_gp = 5;

  localparam int e_late_src_long   = 0;
  localparam int e_late_src_dcache = 1;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic                         fp;
    logic [dword_width_gp-1:0]    data;
  } bp_be_late_wb_entry_s;

  typedef enum logic {e_late_idle = 1'b0, e_late_hold = 1'b1} bp_be_late_wb_state_e;

  function automatic int bp_dword_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? dword_width_gp : 0;
  endfunction

  function automatic int bp_reg_addr_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? reg_addr_width_gp : 0;
  endfunction

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// Single-producer late writeback FIFO with registered full/empty; els_p must be a power of two.
module bp_be_late_wb_fifo
  import bp_be_pkg::*;
#(
  parameter int els_p = 2
)(
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    enq_i,
  input  logic [$bits(bp_be_late_wb_entry_s)-1:0] data_i,
  input  logic                                    deq_i,
  output logic [$bits(bp_be_late_wb_entry_s)-1:0] data_o,
  output logic                                    full_o,
  output logic                                    empty_o,
  output logic                                    empty_next_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [$bits(bp_be_late_wb_entry_s)-1:0] mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic full_q, full_d, empty_q, empty_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wptr_d  = wptr_q + ptr_w_lp'(enq_i);
    rptr_d  = rptr_q + ptr_w_lp'(deq_i);
    full_d  = full_q;
    empty_d = empty_q;
    if (enq_i & ~deq_i) begin
      empty_d = 1'b0;
      full_d  = (wptr_d == rptr_q);
    end else if (deq_i & ~enq_i) begin
      full_d  = 1'b0;
      empty_d = (rptr_d == wptr_q);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o       = mem_q[rptr_q];
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign empty_next_o = empty_d;

endmodule

// File: rtl/bp_be_late_wb_queue.sv
// Late writeback collector: per-source FIFOs, round-robin IDLE/HOLD arbiter, one packet per cycle.
// Optional same-cycle bypass from an empty queue is enabled by defining BP_BE_LATE_WB_BYPASS_EN.
module bp_be_late_wb_queue
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_src_p = 2,
  parameter int els_p     = 2,
  localparam int dword_width_lp    = bp_dword_width(bp_params_p),
  localparam int reg_addr_width_lp = bp_reg_addr_width(bp_params_p),
  localparam int pending_w_lp      = $clog2(num_src_p*els_p+1)
)(
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_src_p-1:0]                   src_v_i,
  output logic [num_src_p-1:0]                   src_ready_o,
  input  logic [num_src_p*reg_addr_width_lp-1:0] src_rd_addr_i,
  input  logic [num_src_p-1:0]                   src_fp_i,
  input  logic [num_src_p*dword_width_lp-1:0]    src_data_i,
  output logic                                   wb_v_o,
  input  logic                                   wb_yumi_i,
  output logic [reg_addr_width_lp-1:0]           wb_rd_addr_o,
  output logic                                   wb_ird_w_v_o,
  output logic                                   wb_frd_w_v_o,
  output logic                                   wb_late_o,
  output logic [dword_width_lp-1:0]              wb_data_o,
  output logic [pending_w_lp-1:0]                pending_o,
  output logic                                   empty_o
);

  localparam int idx_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  bp_be_late_wb_entry_s [num_src_p-1:0] in_li, head_lo;
  bp_be_late_wb_entry_s pres;
  logic [num_src_p-1:0] enq_li, deq_li, full_lo, empty_lo, empty_next_lo, byp_take;
  bp_be_late_wb_state_e state_q, state_d;
  logic [idx_w_lp-1:0] grant_q, grant_d, rr_q, rr_d, byp_sel;
  logic [pending_w_lp-1:0] pending_q, pending_d;
  logic hold_yumi, byp_v, pres_v, found;
  int idx;

  assign hold_yumi = (state_q == e_late_hold) & wb_yumi_i;

  for (genvar gi = 0; gi < num_src_p; gi++) begin : g_src
    assign in_li[gi].rd_addr = src_rd_addr_i[gi*reg_addr_width_lp +: reg_addr_width_lp];
    assign in_li[gi].fp      = src_fp_i[gi];
    assign in_li[gi].data    = src_data_i[gi*dword_width_lp +: dword_width_lp];
    assign enq_li[gi]        = src_v_i[gi] & ~full_lo[gi] & ~byp_take[gi];
    assign deq_li[gi]        = hold_yumi & (grant_q == idx_w_lp'(gi));
    assign byp_take[gi]      = byp_v & wb_yumi_i & (byp_sel == idx_w_lp'(gi));

    bp_be_late_wb_fifo #(.els_p(els_p)) fifo (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .enq_i        (enq_li[gi]),
      .data_i       (in_li[gi]),
      .deq_i        (deq_li[gi]),
      .data_o       (head_lo[gi]),
      .full_o       (full_lo[gi]),
      .empty_o      (empty_lo[gi]),
      .empty_next_o (empty_next_lo[gi])
    );
  end

`ifdef BP_BE_LATE_WB_BYPASS_EN
  // IDLE implies every FIFO is empty, so the bypass only needs a valid input.
  always_comb begin
    byp_v   = 1'b0;
    byp_sel = '0;
    if ((state_q == e_late_idle) && (&empty_lo)) begin
      for (int k = 0; k < num_src_p; k++) begin
        if (!byp_v && src_v_i[(int'(rr_q) + k) % num_src_p]) begin
          byp_v   = 1'b1;
          byp_sel = idx_w_lp'((int'(rr_q) + k) % num_src_p);
        end
      end
    end
  end
`else
  assign byp_v   = 1'b0;
  assign byp_sel = '0;
`endif

  // Arbitrate over the occupancy that will exist after this edge, so an accept
  // at edge t is presented from t+1 and a yumi re-grants without a bubble.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    found   = 1'b0;
    idx     = 0;
    if (hold_yumi) rr_d = idx_w_lp'((int'(grant_q) + 1) % num_src_p);
    else if (byp_v & wb_yumi_i) rr_d = idx_w_lp'((int'(byp_sel) + 1) % num_src_p);
    if ((state_q == e_late_idle) || hold_yumi) begin
      state_d = e_late_idle;
      for (int k = 0; k < num_src_p; k++) begin
        idx = (int'(rr_d) + k) % num_src_p;
        if (!found && !empty_next_lo[idx]) begin
          found   = 1'b1;
          grant_d = idx_w_lp'(idx);
          state_d = e_late_hold;
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q - pending_w_lp'(hold_yumi);
    for (int k = 0; k < num_src_p; k++) pending_d = pending_d + pending_w_lp'(enq_li[k]);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= e_late_idle;
      grant_q   <= '0;
      rr_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
    end
  end

  assign pres_v       = (state_q == e_late_hold) | byp_v;
  assign pres         = byp_v ? in_li[byp_sel] : head_lo[grant_q];
  assign wb_v_o       = pres_v;
  assign wb_late_o    = pres_v;
  assign wb_ird_w_v_o = pres_v & ~pres.fp;
  assign wb_frd_w_v_o = pres_v &  pres.fp;
  assign wb_rd_addr_o = pres_v ? pres.rd_addr : '0;
  assign wb_data_o    = pres_v ? pres.data : '0;
  assign pending_o    = pending_q;
  assign empty_o      = (pending_q == '0);
  assign src_ready_o  = ~full_lo;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(wb_yumi_i && !wb_v_o));

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Self-checking bench for bp_be_late_wb_queue: directed scenarios plus randomized traffic
// against a queue-level reference model (honours BP_BE_LATE_WB_BYPASS_EN when defined).
module tb_bp_be_late_wb_queue;
  localparam int NS = 2, ELS = 2, AW = 5, DW = 64, EW = AW + 1 + DW, PW = $clog2(NS*ELS+1);

  logic clk = 1'b0, reset_n = 1'b0;
  logic [NS-1:0] src_v = '0, src_ready, src_fp = '0;
  logic [NS-1:0][AW-1:0] src_rd = '0;
  logic [NS-1:0][DW-1:0] src_data = '0;
  logic wb_v, wb_yumi = 1'b0, wb_ird, wb_frd, wb_late, empty;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [PW-1:0] pending;
  int checks = 0, errors = 0;

  logic [EW-1:0] mq [NS][$];
  bit m_pres;
  int m_src, m_rr;

  always #5 clk = ~clk;

  bp_be_late_wb_queue #(.num_src_p(NS), .els_p(ELS)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .src_v_i(src_v), .src_ready_o(src_ready),
    .src_rd_addr_i(src_rd), .src_fp_i(src_fp), .src_data_i(src_data),
    .wb_v_o(wb_v), .wb_yumi_i(wb_yumi), .wb_rd_addr_o(wb_rd), .wb_ird_w_v_o(wb_ird),
    .wb_frd_w_v_o(wb_frd), .wb_late_o(wb_late), .wb_data_o(wb_data),
    .pending_o(pending), .empty_o(empty)
  );

  function automatic int model_byp_sel();
    for (int k = 0; k < NS; k++)
      if (src_v[(m_rr + k) % NS]) return (m_rr + k) % NS;
    return -1;
  endfunction

  function automatic bit model_byp();
`ifdef BP_BE_LATE_WB_BYPASS_EN
    return !m_pres && mq[0].size() == 0 && mq[1].size() == 0 && src_v != '0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour at a rising edge, using the inputs present before the edge.
  task automatic model_edge();
    bit acc [NS];
    bit yum, byp;
    int bsel, idx;
    yum  = wb_yumi;
    byp  = model_byp();
    bsel = model_byp_sel();
    for (int s = 0; s < NS; s++) acc[s] = src_v[s] && (mq[s].size() < ELS);
    if (m_pres && yum) begin
      void'(mq[m_src].pop_front());
      m_rr = (m_src + 1) % NS;
    end
    if (byp && yum) begin
      acc[bsel] = 1'b0;
      m_rr = (bsel + 1) % NS;
    end
    for (int s = 0; s < NS; s++) if (acc[s]) mq[s].push_back({src_rd[s], src_fp[s], src_data[s]});
    if (!m_pres || yum) begin
      m_pres = 1'b0;
      for (int k = 0; k < NS; k++) begin
        idx = (m_rr + k) % NS;
        if (!m_pres && mq[idx].size() > 0) begin m_pres = 1'b1; m_src = idx; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [AW-1:0] rd, input logic fp, input logic [DW-1:0] d);
    src_v[s] = 1'b1; src_rd[s] = rd; src_fp[s] = fp; src_data[s] = d;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) mq[s].delete();
    m_pres = 1'b0; m_src = 0; m_rr = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; src_v = '0; wb_yumi = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending !== '0 || wb_v !== 1'b0 || src_ready !== 2'b11 || empty !== 1'b1) begin errors++;
      $display("FAIL reset_state: pending=%0d wb_v=%b ready=%b empty=%b, required 0 0 11 1", pending, wb_v, src_ready, empty); end
    push(0, 5'd1, 1'b0, 64'h11); push(1, 5'd2, 1'b1, 64'h22); tick();
    src_v = '0; push(0, 5'd4, 1'b0, 64'h44); tick(); src_v = '0;
    checks++; if (wb_v !== 1'b1 || pending !== PW'(3)) begin errors++;
      $display("FAIL reset_prefill: wb_v=%b pending=%0d, required 1 3", wb_v, pending); end
    reset_n = 1'b0; #1;
    checks++; if (wb_v !== 1'b0 || pending !== '0 || src_ready !== 2'b11 || empty !== 1'b1 ||
                  wb_rd !== '0 || wb_data !== '0 || wb_ird !== 1'b0 || wb_frd !== 1'b0 || wb_late !== 1'b0) begin errors++;
      $display("FAIL reset_async: wb_v=%b pending=%0d ready=%b empty=%b rd=%0d data=%h late=%b, required 0 0 11 1 0 0 0",
               wb_v, pending, src_ready, empty, wb_rd, wb_data, wb_late); end
    @(negedge clk); reset_n = 1'b1; model_clear(); #1;
    tick();
    checks++; if (wb_v !== 1'b0 || pending !== '0) begin errors++;
      $display("FAIL reset_discard: wb_v=%b pending=%0d, required 0 0", wb_v, pending); end
    $display("test_reset: async reset discarded 3 buffered entries");
  endtask

  task automatic test_single_int();
    do_reset();
    push(1, 5'd5, 1'b0, 64'hDEAD); tick(); src_v = '0;
    checks++; if ({wb_ird, wb_frd, wb_late, wb_rd, wb_data} !== {1'b1, 1'b0, 1'b1, 5'd5, 64'hDEAD}) begin errors++;
      $display("FAIL single_int_pkt: ird=%b frd=%b late=%b rd=%0d data=%h, required 1 0 1 5 dead", wb_ird, wb_frd, wb_late, wb_rd, wb_data); end
    wb_yumi = 1'b1; tick(); wb_yumi = 1'b0;
    checks++; if (empty !== 1'b1 || wb_v !== 1'b0) begin errors++;
      $display("FAIL single_int_empty: empty=%b wb_v=%b, required 1 0", empty, wb_v); end
    $display("test_single_int: src1 rd=5 int data=dead delivered");
  endtask

  task automatic test_simultaneous();
    do_reset();
    push(0, 5'd3, 1'b1, 64'h3333); push(1, 5'd7, 1'b0, 64'h7777); tick(); src_v = '0;
    wb_yumi = 1'b1;
    checks++; if (wb_frd !== 1'b1 || wb_ird !== 1'b0 || wb_rd !== 5'd3 || wb_data !== 64'h3333) begin errors++;
      $display("FAIL simul_first: frd=%b ird=%b rd=%0d data=%h, required 1 0 3 3333", wb_frd, wb_ird, wb_rd, wb_data); end
    tick();
    checks++; if (wb_ird !== 1'b1 || wb_frd !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 64'h7777) begin errors++;
      $display("FAIL simul_second: ird=%b frd=%b rd=%0d data=%h, required 1 0 7 7777", wb_ird, wb_frd, wb_rd, wb_data); end
    tick(); wb_yumi = 1'b0;
    checks++; if (wb_v !== 1'b0 || empty !== 1'b1) begin errors++;
      $display("FAIL simul_drained: wb_v=%b empty=%b, required 0 1", wb_v, empty); end
    push(0, 5'd9, 1'b0, 64'h9); push(1, 5'd10, 1'b0, 64'hA); tick(); src_v = '0;
    checks++; if (wb_rd !== 5'd9) begin errors++;
      $display("FAIL simul_rr_wrap: rd=%0d, required 9", wb_rd); end
    wb_yumi = 1'b1; tick();
    checks++; if (wb_rd !== 5'd10 || wb_v !== 1'b1) begin errors++;
      $display("FAIL simul_rr_second: rd=%0d wb_v=%b, required 10 1", wb_rd, wb_v); end
    tick(); wb_yumi = 1'b0;
    $display("test_simultaneous: rd3 fp then rd7 int, rr back at 0");
  endtask

  task automatic test_backpressure();
    logic [EW+2:0] snap;
    do_reset();
    push(0, 5'd1, 1'b0, 64'hA1); push(1, 5'd2, 1'b1, 64'hB2); tick();
    src_v = '0; push(0, 5'd3, 1'b0, 64'hA3);
    snap = {wb_v, wb_ird, wb_frd, wb_rd, wb_data};
    checks++; if (snap !== {1'b1, 1'b1, 1'b0, 5'd1, 64'hA1}) begin errors++;
      $display("FAIL bp_first: got %h, required %h", snap, {1'b1, 1'b1, 1'b0, 5'd1, 64'hA1}); end
    tick(); src_v = '0;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({wb_v, wb_ird, wb_frd, wb_rd, wb_data} !== snap || src_ready !== 2'b10 || pending !== PW'(3)) begin errors++;
        $display("FAIL bp_hold%0d: pkt=%h ready=%b pending=%0d, required %h 10 3", c, {wb_v, wb_ird, wb_frd, wb_rd, wb_data}, src_ready, pending, snap); end
      tick();
    end
    wb_yumi = 1'b1;
    checks++; if (wb_rd !== 5'd1) begin errors++; $display("FAIL bp_drain0: rd=%0d, required 1", wb_rd); end
    tick();
    checks++; if (wb_rd !== 5'd2 || wb_frd !== 1'b1) begin errors++; $display("FAIL bp_drain1: rd=%0d frd=%b, required 2 1", wb_rd, wb_frd); end
    tick();
    checks++; if (wb_rd !== 5'd3 || wb_data !== 64'hA3) begin errors++; $display("FAIL bp_drain2: rd=%0d data=%h, required 3 a3", wb_rd, wb_data); end
    tick(); wb_yumi = 1'b0;
    checks++; if (wb_v !== 1'b0 || pending !== '0) begin errors++; $display("FAIL bp_drained: wb_v=%b pending=%0d, required 0 0", wb_v, pending); end
    $display("test_backpressure: 3 entries held then drained in 3 cycles");
  endtask

  task automatic test_grant_lock();
    do_reset();
    push(1, 5'd6, 1'b0, 64'h66); tick(); src_v = '0;
    checks++; if (wb_rd !== 5'd6 || wb_v !== 1'b1) begin errors++; $display("FAIL lock_src1: rd=%0d wb_v=%b, required 6 1", wb_rd, wb_v); end
    push(0, 5'd8, 1'b1, 64'h88); tick(); src_v = '0;
    checks++; if (wb_rd !== 5'd6 || wb_data !== 64'h66) begin errors++; $display("FAIL lock_held: rd=%0d data=%h, required 6 66", wb_rd, wb_data); end
    wb_yumi = 1'b1; tick(); wb_yumi = 1'b0;
    checks++; if (wb_rd !== 5'd8 || wb_frd !== 1'b1) begin errors++; $display("FAIL lock_next: rd=%0d frd=%b, required 8 1", wb_rd, wb_frd); end
    wb_yumi = 1'b1; tick(); wb_yumi = 1'b0;
    $display("test_grant_lock: src1 kept grant, src0 followed");
  endtask

  task automatic test_latency();
    do_reset();
    push(0, 5'd4, 1'b0, 64'h4444);
`ifdef BP_BE_LATE_WB_BYPASS_EN
    wb_yumi = 1'b1; #1;
    checks++; if (wb_v !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 64'h4444) begin errors++;
      $display("FAIL bypass_same_cycle: wb_v=%b rd=%0d data=%h, required 1 4 4444", wb_v, wb_rd, wb_data); end
    tick(); src_v = '0; wb_yumi = 1'b0;
    checks++; if (pending !== '0 || wb_v !== 1'b0) begin errors++;
      $display("FAIL bypass_no_enq: pending=%0d wb_v=%b, required 0 0", pending, wb_v); end
    $display("test_latency: bypass delivered rd=4 with no enqueue");
`else
    #1;
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL latency_zero: wb_v=%b, required 0", wb_v); end
    tick(); src_v = '0;
    checks++; if (wb_v !== 1'b1 || wb_rd !== 5'd4) begin errors++; $display("FAIL latency_one: wb_v=%b rd=%0d, required 1 4", wb_v, wb_rd); end
    wb_yumi = 1'b1; tick(); wb_yumi = 1'b0;
    $display("test_latency: rd=4 presented one cycle after accept");
`endif
  endtask

  task automatic test_random();
    logic e_v;
    logic [EW-1:0] e_ent;
    logic [EW+2:0] got, exp;
    int bsel, delivered;
    delivered = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int s = 0; s < NS; s++) begin
        src_v[s] = ($urandom_range(0, 2) != 0);
        src_rd[s] = AW'($urandom); src_fp[s] = 1'($urandom); src_data[s] = {$urandom, $urandom};
      end
      e_v = m_pres;
      e_ent = m_pres ? mq[m_src][0] : '0;
      if (model_byp()) begin
        bsel = model_byp_sel();
        e_v = 1'b1;
        e_ent = {src_rd[bsel], src_fp[bsel], src_data[bsel]};
      end
      wb_yumi = e_v && ($urandom_range(0, 3) < (((c / 100) % 2 == 1) ? 1 : 3));
      #1;
      got = {wb_v, wb_ird, wb_frd, wb_rd, wb_data};
      exp = e_v ? {1'b1, ~e_ent[DW], e_ent[DW], e_ent[EW-1 -: AW], e_ent[DW-1:0]} : '0;
      checks++; if (got !== exp || wb_late !== e_v) begin errors++;
        $display("FAIL rand_pkt c=%0d: got %h late=%b, required %h late=%b", c, got, wb_late, exp, e_v); end
      checks++; if (pending !== PW'(mq[0].size() + mq[1].size()) ||
                    src_ready !== {mq[1].size() < ELS, mq[0].size() < ELS} ||
                    empty !== (mq[0].size() + mq[1].size() == 0)) begin errors++;
        $display("FAIL rand_occ c=%0d: pending=%0d ready=%b empty=%b, required %0d %b%b %b", c, pending, src_ready, empty,
                 mq[0].size() + mq[1].size(), mq[1].size() < ELS, mq[0].size() < ELS, mq[0].size() + mq[1].size() == 0); end
      if (wb_yumi) delivered++;
      tick();
    end
    src_v = '0; wb_yumi = 1'b0;
    $display("test_random: 800 cycles, %0d packets delivered", delivered);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_single_int();
    test_simultaneous();
    test_backpressure();
    test_grant_lock();
    test_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
